// File: rtl/dmem_timer_bus.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_timer_bus
//  Description : Data-side slave for the MEM stage. Decodes each access to a
//                word-addressed data RAM or to a memory-mapped down-counting
//                timer whose level interrupt feeds the core's int input.
//                Optional macro DMEM_TIMER_PRESCALE_EN adds a 16-bit PRESCALE
//                register (offset 0x10) and a tick prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_timer_bus #(
  parameter int          RAM_AW     = 10,
  parameter logic [15:0] TIMER_PAGE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        timer_irq
);

  localparam int         c_ramDepth  = 1 << RAM_AW;
  localparam logic [2:0] c_offCtrl   = 3'd0;
  localparam logic [2:0] c_offLoad   = 3'd1;
  localparam logic [2:0] c_offCount  = 3'd2;
  localparam logic [2:0] c_offStatus = 3'd3;
  localparam logic [2:0] c_offPre    = 3'd4;

  // Word storage; contents survive reset
  logic [31:0] r_mem [0:c_ramDepth-1];

  // Timer state
  logic        r_en;
  logic        r_auto;
  logic        r_ie;
  logic        r_exp;
  logic [31:0] r_load;
  logic [31:0] r_count;

  // Bus decode
  logic              w_timerSel;
  logic [RAM_AW-1:0] w_ramIdx;
  logic [2:0]        w_off;
  logic              w_rdEn;
  logic              w_wrEn;
  logic              w_ramWr;
  logic              w_timerWr;
  logic              w_ctrlWr;
  logic              w_loadWr;
  logic              w_statusWr;
  logic              w_preWr;
  logic              w_tick;
  logic              w_expire;
  logic [31:0]       w_timerRd;
  logic              w_unusedAddr;

  // rst is active-low: bus accesses only take effect while it is high
  assign w_timerSel = (memAddr[31:16] == TIMER_PAGE);
  assign w_ramIdx   = memAddr[RAM_AW+1:2];
  assign w_off      = memAddr[4:2];
  assign w_rdEn     = rst & memCe & ~memWr;
  assign w_wrEn     = rst & memCe & memWr;
  assign w_ramWr    = w_wrEn & ~w_timerSel;
  assign w_timerWr  = w_wrEn & w_timerSel;
  assign w_ctrlWr   = w_timerWr & (w_off == c_offCtrl);
  assign w_loadWr   = w_timerWr & (w_off == c_offLoad);
  assign w_statusWr = w_timerWr & (w_off == c_offStatus);
  assign w_preWr    = w_timerWr & (w_off == c_offPre);

  // Address bits between the RAM index and the page select are don't-care
  assign w_unusedAddr = &{1'b0, memAddr};

`ifdef DMEM_TIMER_PRESCALE_EN
  logic [15:0] r_prescale;
  logic [15:0] r_preCnt;

  // A tick fires when the prescale counter reaches PRESCALE
  assign w_tick = r_en & (r_preCnt == r_prescale);

  // Prescale register and counter; counter restarts on every tick,
  // whenever the timer is disabled, and on any PRESCALE write
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prescale <= '0;
      r_preCnt   <= '0;
    end else begin
      if (w_preWr) begin
        r_prescale <= wtData[15:0];
      end
      if (w_preWr || !r_en || w_tick) begin
        r_preCnt <= '0;
      end else begin
        r_preCnt <= r_preCnt + 16'd1;
      end
    end
  end
`else
  // Without the prescaler every enabled cycle is a tick; offset 0x10 is inert
  assign w_tick = r_en;
  logic w_unusedPre;
  assign w_unusedPre = w_preWr;
`endif

  // A LOAD write on the same edge suppresses expiry
  assign w_expire = w_tick & (r_count == 32'd0) & ~w_loadWr;

  // Data RAM write port
  always_ff @(posedge clk) begin
    if (w_ramWr) begin
      r_mem[w_ramIdx] <= wtData;
    end
  end

  // Timer registers and down-counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
      r_ie    <= 1'b0;
      r_exp   <= 1'b0;
      r_load  <= '0;
      r_count <= '0;
    end else begin
      // LOAD write reloads COUNT immediately and preempts the tick
      if (w_loadWr) begin
        r_load  <= wtData;
        r_count <= wtData;
      end else if (w_tick) begin
        if (r_count != 32'd0) begin
          r_count <= r_count - 32'd1;
        end else if (r_auto) begin
          r_count <= r_load;
        end
      end

      // Expiry beats a same-edge write-1-clear
      if (w_expire) begin
        r_exp <= 1'b1;
      end else if (w_statusWr && wtData[0]) begin
        r_exp <= 1'b0;
      end

      // A CTRL write beats the one-shot auto-disable
      if (w_ctrlWr) begin
        r_en   <= wtData[0];
        r_auto <= wtData[1];
        r_ie   <= wtData[2];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end
    end
  end

  // Timer register read mux; unmapped offsets return 0
  always_comb begin
    w_timerRd = '0;
    case (w_off)
      c_offCtrl:   w_timerRd = {29'd0, r_ie, r_auto, r_en};
      c_offLoad:   w_timerRd = r_load;
      c_offCount:  w_timerRd = r_count;
      c_offStatus: w_timerRd = {31'd0, r_exp};
`ifdef DMEM_TIMER_PRESCALE_EN
      c_offPre:    w_timerRd = {16'd0, r_prescale};
`endif
      default:     w_timerRd = '0;
    endcase
  end

  // Zero-latency read data; zero when not a read or while in reset
  always_comb begin
    rdData = '0;
    if (w_rdEn) begin
      rdData = w_timerSel ? w_timerRd : r_mem[w_ramIdx];
    end
  end

  assign timer_irq = r_exp & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_dmem_timer_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_timer_bus
//  Description : Scoreboard bench for dmem_timer_bus. Directed scenarios use
//                hand-derived constants; random traffic uses a behavioural
//                model of the RAM and timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_timer_bus;

  localparam logic [31:0] c_tBase = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memCe = 1'b0;
  logic        memWr = 1'b0;
  logic [31:0] memAddr = '0;
  logic [31:0] wtData = '0;
  logic [31:0] rdData;
  logic        timer_irq;

  dmem_timer_bus #(.RAM_AW(10), .TIMER_PAGE(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .memCe(memCe), .memWr(memWr),
    .memAddr(memAddr), .wtData(wtData), .rdData(rdData), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   passCnt  = 0;
  int   totalCnt = 0;

  // Behavioural model state
  logic [31:0] mRam [int];
  logic        mEn = 0, mAuto = 0, mIe = 0, mExp = 0;
  logic [31:0] mLoad = 0, mCount = 0;
  logic [15:0] mPre = 0, mPc = 0;

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a[31:16] == 16'hFFFF) begin
      case (a[4:2])
        3'd0: return {29'd0, mIe, mAuto, mEn};
        3'd1: return mLoad;
        3'd2: return mCount;
        3'd3: return {31'd0, mExp};
`ifdef DMEM_TIMER_PRESCALE_EN
        3'd4: return {16'd0, mPre};
`endif
        default: return 32'd0;
      endcase
    end
    if (mRam.exists(int'(a[11:2]))) return mRam[int'(a[11:2])];
    return 32'd0;
  endfunction

  // Apply one clock edge's worth of the timer/RAM rules to the model
  task automatic modelEdge(input logic r, input logic ce, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
    logic tw, ldW, ctW, stW, prW, tick, expire;
    logic [31:0] nCount;
    logic nEn, nExp;
    if (!r) begin
      mEn = 0; mAuto = 0; mIe = 0; mExp = 0;
      mLoad = 0; mCount = 0; mPre = 0; mPc = 0;
      return;
    end
    tw  = ce && wr && (a[31:16] == 16'hFFFF);
    ldW = tw && a[4:2] == 3'd1;
    ctW = tw && a[4:2] == 3'd0;
    stW = tw && a[4:2] == 3'd3;
    prW = tw && a[4:2] == 3'd4;
    if (ce && wr && !tw) mRam[int'(a[11:2])] = d;
`ifdef DMEM_TIMER_PRESCALE_EN
    tick = mEn && (mPc == mPre);
`else
    tick = mEn;
`endif
    expire = tick && mCount == 0 && !ldW;
    if (ldW)                 nCount = d;
    else if (!tick)          nCount = mCount;
    else if (mCount != 0)    nCount = mCount - 1;
    else                     nCount = mAuto ? mLoad : 32'd0;
    nEn  = ctW ? d[0] : ((expire && !mAuto) ? 1'b0 : mEn);
    nExp = expire ? 1'b1 : ((stW && d[0]) ? 1'b0 : mExp);
`ifdef DMEM_TIMER_PRESCALE_EN
    mPc  = (prW || !mEn || tick) ? 16'd0 : mPc + 16'd1;
    if (prW) mPre = d[15:0];
`else
    if (prW) mPre = mPre;
`endif
    if (ctW) begin mAuto = d[1]; mIe = d[2]; end
    if (ldW) mLoad = d;
    mCount = nCount;
    mEn    = nEn;
    mExp   = nExp;
  endtask

  // One bus cycle; reads push either a fixed expectation or the model's
  task automatic op(input logic r, input logic ce, input logic wr,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic useConst, input logic [31:0] cData,
                    input logic cIrq, input string nm);
    exp_t e;
    rst = r; memCe = ce; memWr = wr; memAddr = a; wtData = d;
    if (ce && !wr) begin
      e.name = nm;
      if (useConst) begin
        e.data = cData;
        e.irq  = cIrq;
      end else begin
        e.data = r ? modelRead(a) : 32'd0;
        e.irq  = mExp & mIe;
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    modelEdge(r, ce, wr, a, d);
    #1;
  endtask

  task automatic wrB(input logic [31:0] a, input logic [31:0] d);
    op(1'b1, 1'b1, 1'b1, a, d, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic rdK(input logic [31:0] a, input logic [31:0] d,
                     input logic irq, input string nm);
    op(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b1, d, irq, nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    totalCnt++;
    if (act === expv) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  // Monitor: every presented read is matched against the scoreboard head
  always @(negedge clk) begin
    if (memCe && !memWr) begin
      if (sbq.size() == 0) begin
        totalCnt++;
        $display("FAIL scoreboard_empty: got read with no expectation at %0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_rd"}, rdData, e.data);
        chk({e.name, "_irq"}, {31'd0, timer_irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]  pool [16];
    logic [31:0] a, d;
    int          k, off;

    @(posedge clk); #1;
    // Reset: reads give 0, writes are ignored
    op(1'b0, 1'b1, 1'b0, c_tBase + 8, 32'd0, 1'b1, 32'd0, 1'b0, "rst_rd");
    op(1'b0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'd0, 1'b0, "");

    // RAM write/read and aliasing
    wrB(32'h40, 32'hDEAD_BEEF);
    rdK(32'h40, 32'hDEAD_BEEF, 1'b0, "ram_rd");
    rdK(32'h1040, 32'hDEAD_BEEF, 1'b0, "ram_alias");

    // Auto-reload: LOAD=3
    wrB(c_tBase + 4, 32'd3);
    wrB(c_tBase + 0, 32'd7);
    rdK(c_tBase + 8, 32'd3, 1'b0, "auto_c3");
    rdK(c_tBase + 8, 32'd2, 1'b0, "auto_c2");
    rdK(c_tBase + 8, 32'd1, 1'b0, "auto_c1");
    rdK(c_tBase + 8, 32'd0, 1'b0, "auto_c0");
    rdK(c_tBase + 8, 32'd3, 1'b1, "auto_reload");
    rdK(c_tBase + 12, 32'd1, 1'b1, "auto_exp");
    wrB(c_tBase + 0, 32'd0);
    wrB(c_tBase + 12, 32'd1);
    rdK(c_tBase + 12, 32'd0, 1'b0, "auto_clr");

    // One-shot: LOAD=2, CTRL=EN|IE
    wrB(c_tBase + 4, 32'd2);
    wrB(c_tBase + 0, 32'd5);
    rdK(c_tBase + 8, 32'd2, 1'b0, "os_c2");
    rdK(c_tBase + 8, 32'd1, 1'b0, "os_c1");
    rdK(c_tBase + 8, 32'd0, 1'b0, "os_c0");
    rdK(c_tBase + 0, 32'd4, 1'b1, "os_en0");
    rdK(c_tBase + 8, 32'd0, 1'b1, "os_hold0");
    wrB(c_tBase + 12, 32'd1);
    rdK(c_tBase + 12, 32'd0, 1'b0, "os_clr");

    // Write-1-clear on the same edge as expiry: expiry wins
    wrB(c_tBase + 4, 32'd0);
    wrB(c_tBase + 0, 32'd7);
    wrB(c_tBase + 12, 32'd1);
    rdK(c_tBase + 12, 32'd1, 1'b1, "clr_vs_exp");
    wrB(c_tBase + 0, 32'd0);
    wrB(c_tBase + 12, 32'd1);
    rdK(c_tBase + 12, 32'd0, 1'b0, "clr_stopped");

    // Reset mid-count
    wrB(c_tBase + 4, 32'd10);
    wrB(c_tBase + 0, 32'd7);
    for (int i = 10; i >= 5; i--) rdK(c_tBase + 8, 32'(i), 1'b0, "mid_cnt");
    op(1'b0, 1'b1, 1'b0, c_tBase + 8, 32'd0, 1'b1, 32'd0, 1'b0, "mid_rst");
    rdK(c_tBase + 0, 32'd0, 1'b0, "rst_ctrl");
    rdK(c_tBase + 4, 32'd0, 1'b0, "rst_load");
    rdK(c_tBase + 8, 32'd0, 1'b0, "rst_count");
    rdK(c_tBase + 12, 32'd0, 1'b0, "rst_status");
    rdK(32'h40, 32'hDEAD_BEEF, 1'b0, "ram_keep");

    // Offset 0x10
    wrB(c_tBase + 16, 32'h0000_0005);
`ifdef DMEM_TIMER_PRESCALE_EN
    rdK(c_tBase + 16, 32'd5, 1'b0, "pre_rd");
    wrB(c_tBase + 16, 32'd1);
    wrB(c_tBase + 4, 32'd2);
    wrB(c_tBase + 0, 32'd7);
    rdK(c_tBase + 8, 32'd2, 1'b0, "pre_c2a");
    rdK(c_tBase + 8, 32'd2, 1'b0, "pre_c2b");
    rdK(c_tBase + 8, 32'd1, 1'b0, "pre_c1a");
    rdK(c_tBase + 8, 32'd1, 1'b0, "pre_c1b");
    rdK(c_tBase + 8, 32'd0, 1'b0, "pre_c0a");
    rdK(c_tBase + 8, 32'd0, 1'b0, "pre_c0b");
    rdK(c_tBase + 12, 32'd1, 1'b1, "pre_exp");
    wrB(c_tBase + 0, 32'd0);
    wrB(c_tBase + 12, 32'd1);
    wrB(c_tBase + 16, 32'd0);
`else
    rdK(c_tBase + 16, 32'd0, 1'b0, "pre_absent");
`endif

    // Randomised traffic against the model
    for (int p = 0; p < 16; p++) begin
      pool[p] = 10'((p * 61) & 1023);
      wrB({20'd0, pool[p], 2'b00}, $urandom);
    end
    for (int n = 0; n < 1500; n++) begin
      k = $urandom_range(0, 99);
      a = ($urandom & 32'h0FFF_F000) | {20'd0, pool[$urandom_range(0, 15)], 2'b00}
          | 32'($urandom_range(0, 3));
      if (k < 1) begin
        op(1'b0, 1'($urandom), 1'($urandom), a, $urandom, 1'b0, 32'd0, 1'b0, "rnd_rst");
      end else if (k < 25) begin
        wrB(a, $urandom);
      end else if (k < 45) begin
        op(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0, 1'b0, "rnd_ram");
      end else if (k < 62) begin
        a = c_tBase | ($urandom & 32'h0000_FFE0) | 32'($urandom_range(0, 7) << 2);
        op(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0, 1'b0, "rnd_tmr");
      end else if (k < 88) begin
        off = $urandom_range(0, 4);
        a = c_tBase | ($urandom & 32'h0000_FFE0) | 32'(off << 2);
        case (off)
          1:       d = 32'($urandom_range(0, 6));
          4:       d = 32'($urandom_range(0, 3));
          default: d = $urandom;
        endcase
        wrB(a, d);
      end else begin
        op(1'b1, 1'b0, 1'($urandom), a, $urandom, 1'b0, 32'd0, 1'b0, "");
      end
    end

    op(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, "");
    op(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, "");
    if (sbq.size() != 0) begin
      totalCnt++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_timer_bus.md
Name: dmem_timer_bus

Overview:
- Data-side slave for the core's MEM stage. It consumes memCe/memWr/memAddr/wtData and returns rdData in the same cycle.
- Decodes each access to a word-addressed data RAM or to a memory-mapped down-counting timer.
- The timer's interrupt output drives the core's external interrupt input into CP0.

Parameters:
- RAM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
- TIMER_PAGE, 16'hFFFF, value of memAddr[31:16] that selects the timer register page.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on clk rising edge.
- memCe  in  1  access enable from MEM stage.
- memWr  in  1  1 = write, 0 = read; valid only when memCe=1.
- memAddr  in  32  byte address; bits [1:0] ignored (word accesses only).
- wtData  in  32  write data.
- rdData  out  32  read data, combinational, same cycle as request.
- timer_irq  out  1  level interrupt to the core's int input (bit 0).

Behaviour:
- Reset (rst=0 at clk edge):
  - All timer registers clear to 0; timer_irq=0.
  - RAM contents are not cleared.
  - While rst=0, rdData=0 and writes are ignored.
- Decode:
  - Timer region when memAddr[31:16]==TIMER_PAGE; RAM region otherwise.
  - RAM index = memAddr[RAM_AW+1:2]; upper bits are ignored, so addresses alias (wrap) modulo RAM size.
- Reads:
  - memCe=1, memWr=0 → rdData = RAM word or timer register, combinational, zero latency.
  - memCe=0 or memWr=1 → rdData=0.
  - Unmapped timer offsets read 0.
- Writes: memCe=1, memWr=1 → target updated at next clk edge. Read-after-write to the same address in the following cycle returns the new data.
- Timer registers (offset = memAddr[4:2]):
  - 0x0 CTRL, RW: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable). Other bits read 0.
  - 0x4 LOAD, RW: reload value. A write also copies wtData into COUNT on the same edge.
  - 0x8 COUNT, RO: current count. Writes are ignored.
  - 0xC STATUS, bit0 EXP: read; write 1 to clear, write 0 has no effect.
- Counter, on each tick while EN=1:
  - If COUNT!=0: COUNT <= COUNT-1.
  - If COUNT==0: EXP <= 1.
    - AUTO=1: COUNT <= LOAD.
    - AUTO=0: EN <= 0 (one-shot) and COUNT stays 0.
  - With no prescaler, a tick occurs every cycle.
  - Timing example: LOAD=N, AUTO=1 gives EXP every N+1 ticks.
- timer_irq = EXP & IE, taken from registered state (no combinational path from bus inputs).
- Simultaneous events:
  - Expiry and STATUS write-1-clear on the same edge → expiry wins, EXP stays 1.
  - Expiry and CTRL write on the same edge → CTRL written value wins for EN/AUTO/IE; EXP is still set.
  - LOAD write and tick on the same edge → COUNT takes wtData; decrement/expiry is suppressed that cycle.
  - LOAD=0 with AUTO=1 → expires every tick.
- Reset mid-count: timer returns to all-zero state on that edge; no residual irq.

Optional Feature:
- Macro DMEM_TIMER_PRESCALE_EN.
- Defined:
  - Adds register 0x10 PRESCALE (RW, 16 bits, reset 0) and a 16-bit prescale counter.
  - A tick fires when the prescale counter equals PRESCALE; the counter then returns to 0.
  - The prescale counter clears on reset, when EN=0, and on any PRESCALE write.
  - PRESCALE=0 is equivalent to a tick every cycle.
- Not defined: a tick occurs every cycle; offset 0x10 reads 0 and writes to it are ignored.

Test Plan:
- Write RAM 0x0000_0040 = 32'hDEADBEEF, then read 0x0000_0040 next cycle → rdData=32'hDEADBEEF. Read 0x0000_1040 (alias, RAM_AW=10) → same value.
- Write LOAD=3, CTRL=3'b111 → COUNT reads 3,2,1,0 on consecutive cycles. EXP=1 and timer_irq=1 the cycle after COUNT=0; COUNT reloads to 3.
- LOAD=2, CTRL=3'b101 (one-shot) → after expiry, CTRL.EN reads 0, COUNT stays 0, timer_irq stays 1 until STATUS write 1. timer_irq=0 the cycle after the write.
- Force STATUS write-1 on the same edge as expiry (LOAD=0, AUTO=1) → EXP remains 1, timer_irq=1.
- Mid-count (COUNT=5), assert rst=0 for one edge → CTRL/LOAD/COUNT/STATUS read 0, timer_irq=0. A RAM word written earlier still reads its prior value.
- With DMEM_TIMER_PRESCALE_EN: PRESCALE=1, LOAD=2, CTRL=3'b111 → COUNT decrements every 2 cycles; first expiry 6 cycles after enable. Without the macro, offset 0x10 reads 0 after writing 16'h0005.
